// File: rtl/cp0_reg_pkg.sv
// Shared CP0 constants: register numbers, exception-type codes, field positions.
// Used by cp0_reg and cp0_timer.
package cp0_reg_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RAW  = 5;

    // Register numbers
    localparam logic [RAW-1:0] CP0_BADVADDR = 5'd8;
    localparam logic [RAW-1:0] CP0_COUNT    = 5'd9;
    localparam logic [RAW-1:0] CP0_COMPARE  = 5'd11;
    localparam logic [RAW-1:0] CP0_STATUS   = 5'd12;
    localparam logic [RAW-1:0] CP0_CAUSE    = 5'd13;
    localparam logic [RAW-1:0] CP0_EPC      = 5'd14;

    // Exception-type codes from M-stage decode
    localparam logic [XLEN-1:0] EXC_NONE = 32'h0;
    localparam logic [XLEN-1:0] EXC_INT  = 32'h1;
    localparam logic [XLEN-1:0] EXC_ADEL = 32'h4;
    localparam logic [XLEN-1:0] EXC_ADES = 32'h5;
    localparam logic [XLEN-1:0] EXC_SYS  = 32'h8;
    localparam logic [XLEN-1:0] EXC_BP   = 32'h9;
    localparam logic [XLEN-1:0] EXC_RI   = 32'ha;
    localparam logic [XLEN-1:0] EXC_OV   = 32'hc;
    localparam logic [XLEN-1:0] EXC_ERET = 32'he;

    // Field positions
    localparam int unsigned STATUS_IE  = 0;
    localparam int unsigned STATUS_EXL = 1;
    localparam int unsigned CAUSE_BD   = 31;
    localparam int unsigned CAUSE_IP_LO  = 10;
    localparam int unsigned CAUSE_EXC_LO = 2;

    // MTC0-writable bits
    localparam logic [XLEN-1:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [XLEN-1:0] CAUSE_WMASK  = 32'h0000_0300;

    // True for exception types that commit EPC/Cause/EXL (ERET excluded)
    function automatic logic is_exception(input logic [XLEN-1:0] t);
        return (t == EXC_INT)  || (t == EXC_ADEL) || (t == EXC_ADES) ||
               (t == EXC_SYS)  || (t == EXC_BP)   || (t == EXC_RI)   ||
               (t == EXC_OV);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with sticky timer interrupt.
// Ports: clk, rst (sync, active-high), we/waddr/data (MTC0, already flush-gated),
//        count/compare (register values), timer_int (sticky pending flag).
// Optional: CP0_COUNT_DIV2_EN makes Count advance every second cycle.
module cp0_timer
    import cp0_reg_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [RAW-1:0]  waddr,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] count,
    output logic [XLEN-1:0] compare,
    output logic            timer_int
);

    logic wr_count;
    logic wr_compare;
    logic inc;

    assign wr_count   = we && (waddr == CP0_COUNT);
    assign wr_compare = we && (waddr == CP0_COMPARE);

`ifdef CP0_COUNT_DIV2_EN
    // Half-rate gate; a Count write restarts the phase
    logic toggle;
    always_ff @(posedge clk) begin
        if (rst)           toggle <= 1'b0;
        else if (wr_count) toggle <= 1'b0;
        else               toggle <= ~toggle;
    end
    assign inc = toggle;
`else
    assign inc = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            compare   <= '0;
            timer_int <= 1'b0;
        end else begin
            if (wr_count)  count <= data;
            else if (inc)  count <= count + XLEN'(1);

            // Compare write acknowledges the interrupt; Compare==0 disables matching
            if (wr_compare) begin
                compare   <= data;
                timer_int <= 1'b0;
            end else if ((count == compare) && (compare != '0)) begin
                timer_int <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_reg.sv
// CP0 register file: exception commit, MTC0/MFC0, interrupt sampling.
// Ports: clk, rst (sync, active-high); we_i/waddr_i/data_i MTC0; raddr_i/data_o MFC0
//        (combinational read); int_i hardware interrupts; except_type_i,
//        current_inst_addr_i, is_in_delayslot_i, bad_addr_i from exception decode;
//        badvaddr_o..epc_o register values; timer_int_o timer pending.
// Build option: CP0_COUNT_DIV2_EN (half-rate Count, inside cp0_timer).
module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [RAW-1:0]  waddr_i,
    input  logic [RAW-1:0]  raddr_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [5:0]      int_i,
    input  logic [XLEN-1:0] except_type_i,
    input  logic [XLEN-1:0] current_inst_addr_i,
    input  logic            is_in_delayslot_i,
    input  logic [XLEN-1:0] bad_addr_i,
    output logic [XLEN-1:0] data_o,
    output logic [XLEN-1:0] badvaddr_o,
    output logic [XLEN-1:0] count_o,
    output logic [XLEN-1:0] compare_o,
    output logic [XLEN-1:0] status_o,
    output logic [XLEN-1:0] cause_o,
    output logic [XLEN-1:0] epc_o,
    output logic            timer_int_o
);

    logic exc;
    logic eret;
    logic mtc0;

    assign exc  = is_exception(except_type_i);
    assign eret = (except_type_i == EXC_ERET);
    // The MTC0 is flushed whenever an exception or ERET commits this cycle
    assign mtc0 = we_i && !exc && !eret;

    cp0_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .we        (mtc0),
        .waddr     (waddr_i),
        .data      (data_i),
        .count     (count_o),
        .compare   (compare_o),
        .timer_int (timer_int_o)
    );

    // Status / Cause / EPC / BadVAddr
    always_ff @(posedge clk) begin
        if (rst) begin
            status_o   <= RESET_STATUS;
            cause_o    <= '0;
            epc_o      <= '0;
            badvaddr_o <= '0;
        end else begin
            // IP7 carries the timer; sampled every cycle
            cause_o[15:CAUSE_IP_LO] <= {int_i[5] | timer_int_o, int_i[4:0]};

            if (exc) begin
                if (!status_o[STATUS_EXL]) begin
                    epc_o             <= is_in_delayslot_i ? current_inst_addr_i - XLEN'(4)
                                                           : current_inst_addr_i;
                    cause_o[CAUSE_BD] <= is_in_delayslot_i;
                end
                status_o[STATUS_EXL] <= 1'b1;
                cause_o[6:CAUSE_EXC_LO] <= (except_type_i == EXC_INT) ? 5'd0
                                                                      : except_type_i[4:0];
                if ((except_type_i == EXC_ADEL) || (except_type_i == EXC_ADES))
                    badvaddr_o <= bad_addr_i;
            end else if (eret) begin
                status_o[STATUS_EXL] <= 1'b0;
            end else if (mtc0) begin
                case (waddr_i)
                    CP0_STATUS: status_o <= (status_o & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
                    CP0_CAUSE:  cause_o[9:8] <= data_i[9:8];
                    CP0_EPC:    epc_o <= data_i;
                    default:    ;
                endcase
            end
        end
    end

    // MFC0 read mux; no write bypass
    always_comb begin
        data_o = '0;
        case (raddr_i)
            CP0_BADVADDR: data_o = badvaddr_o;
            CP0_COUNT:    data_o = count_o;
            CP0_COMPARE:  data_o = compare_o;
            CP0_STATUS:   data_o = status_o;
            CP0_CAUSE:    data_o = cause_o;
            CP0_EPC:      data_o = epc_o;
            default:      data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg: directed scenarios then random traffic,
// all outputs compared against an architectural model every cycle.
module tb_cp0_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i, raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] except_type_i, current_inst_addr_i, bad_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] data_o, badvaddr_o, count_o, compare_o, status_o, cause_o, epc_o;
    logic        timer_int_o;

    int vectors = 0;
    int miscompares = 0;

    // Architectural model state
    logic [31:0] m_badv, m_count, m_cmp, m_status, m_cause, m_epc;
    logic        m_tint, m_tog;

    always #5 clk = ~clk;

    cp0_reg dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
        .data_i(data_i), .int_i(int_i), .except_type_i(except_type_i),
        .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
        .bad_addr_i(bad_addr_i), .data_o(data_o), .badvaddr_o(badvaddr_o),
        .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
        .cause_o(cause_o), .epc_o(epc_o), .timer_int_o(timer_int_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_cmp;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    // Apply one cycle of the architectural rules to the model
    task automatic m_update;
        logic is_exc, is_eret, mtc;
        logic [31:0] et;
        et = except_type_i;
        if (rst) begin
            m_badv = 0; m_count = 0; m_cmp = 0; m_status = 32'h0040_0000;
            m_cause = 0; m_epc = 0; m_tint = 0; m_tog = 0;
            return;
        end
        is_exc  = (et == 1) || (et == 4) || (et == 5) || (et == 8) ||
                  (et == 9) || (et == 10) || (et == 12);
        is_eret = (et == 14);
        mtc     = we_i && !is_exc && !is_eret;

        m_cause[15:10] = {int_i[5] | m_tint, int_i[4:0]};

        if (mtc && waddr_i == 11) m_tint = 0;
        else if (m_count == m_cmp && m_cmp != 0) m_tint = 1;
        if (mtc && waddr_i == 11) m_cmp = data_i;

`ifdef CP0_COUNT_DIV2_EN
        if (mtc && waddr_i == 9) begin m_count = data_i; m_tog = 0; end
        else begin m_count = m_count + {31'd0, m_tog}; m_tog = ~m_tog; end
`else
        if (mtc && waddr_i == 9) m_count = data_i;
        else m_count = m_count + 1;
`endif

        if (is_exc) begin
            if (!m_status[1]) begin
                m_epc = is_in_delayslot_i ? current_inst_addr_i - 4 : current_inst_addr_i;
                m_cause[31] = is_in_delayslot_i;
            end
            m_status[1] = 1'b1;
            m_cause[6:2] = (et == 1) ? 5'd0 : et[4:0];
            if (et == 4 || et == 5) m_badv = bad_addr_i;
        end else if (is_eret) begin
            m_status[1] = 1'b0;
        end else if (mtc) begin
            if (waddr_i == 12) m_status = (m_status & ~32'h0000_FF03) | (data_i & 32'h0000_FF03);
            if (waddr_i == 13) m_cause[9:8] = data_i[9:8];
            if (waddr_i == 14) m_epc = data_i;
        end
    endtask

    // One clock: drive, check read mux, clock edge, update model, check all registers
    task automatic step(input logic r, input logic w, input logic [4:0] wa, input logic [4:0] ra,
                        input logic [31:0] d, input logic [5:0] iv, input logic [31:0] et,
                        input logic [31:0] pc, input logic ds, input logic [31:0] ba);
        rst = r; we_i = w; waddr_i = wa; raddr_i = ra; data_i = d; int_i = iv;
        except_type_i = et; current_inst_addr_i = pc; is_in_delayslot_i = ds; bad_addr_i = ba;
        #1;
        if (!r) chk("data_o", data_o, m_read(ra));
        @(posedge clk);
        m_update();
        #1;
        chk("badvaddr", badvaddr_o, m_badv);
        chk("count", count_o, m_count);
        chk("compare", compare_o, m_cmp);
        chk("status", status_o, m_status);
        chk("cause", cause_o, m_cause);
        chk("epc", epc_o, m_epc);
        chk("timer_int", {31'd0, timer_int_o}, {31'd0, m_tint});
    endtask

    task automatic idle(input logic [4:0] ra);
        step(0, 0, 0, ra, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic mtc0(input logic [4:0] wa, input logic [31:0] d);
        step(0, 1, wa, 12, d, 0, 0, 0, 0, 0);
    endtask

    localparam logic [4:0] WA_TAB [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd3};
    localparam logic [31:0] ET_TAB [11] = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha,
                                            32'hc, 32'he, 32'h2, 32'h7, 32'h13};

    initial begin
        int guard;
        logic [4:0]  wa, ra;
        logic [31:0] et, d;

        // Reset and reset-state reads
        step(1, 0, 0, 12, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 12, 0, 0, 0, 0, 0, 0);
        rst = 0; raddr_i = 12; #1;
        chk("reset_mfc0_status", data_o, 32'h0040_0000);
        raddr_i = 9; #1;
        chk("reset_mfc0_count", data_o, 32'h0);
        chk("reset_timer_int", {31'd0, timer_int_o}, 32'h0);
        idle(9);
`ifdef CP0_COUNT_DIV2_EN
        chk("count_first", count_o, 32'd0);
        idle(9);
        chk("count_second", count_o, 32'd1);
`else
        chk("count_first", count_o, 32'd1);
        idle(9);
        chk("count_second", count_o, 32'd2);
`endif

        // Timer interrupt
        mtc0(11, 32'd20);
        mtc0(9, 32'd10);
        chk("count_loaded", count_o, 32'd10);
        guard = 0;
        while (count_o != 32'd20 && guard < 100) begin idle(9); guard++; end
        chk("count_reach_20", count_o, 32'd20);
        chk("tint_before", {31'd0, timer_int_o}, 32'h0);
        idle(13);
        chk("tint_rise", {31'd0, timer_int_o}, 32'h1);
        chk("ip7_lag", {31'd0, cause_o[15]}, 32'h0);
        idle(13);
        chk("ip7_follow", {31'd0, cause_o[15]}, 32'h1);
        mtc0(11, 32'd0);
        chk("tint_clear", {31'd0, timer_int_o}, 32'h0);

        // AdES in delay slot
        step(0, 0, 0, 14, 0, 0, 32'h5, 32'hBFC0_1000, 1, 32'h3);
        chk("ades_epc", epc_o, 32'hBFC0_0FFC);
        chk("ades_bd", {31'd0, cause_o[31]}, 32'h1);
        chk("ades_exccode", {27'd0, cause_o[6:2]}, 32'd5);
        chk("ades_badv", badvaddr_o, 32'h3);
        chk("ades_exl", {31'd0, status_o[1]}, 32'h1);

        // Nested Syscall, then ERET
        step(0, 0, 0, 14, 0, 0, 32'h8, 32'h8000_0100, 0, 0);
        chk("nested_epc", epc_o, 32'hBFC0_0FFC);
        chk("nested_exccode", {27'd0, cause_o[6:2]}, 32'd8);
        step(0, 0, 0, 14, 0, 0, 32'he, 32'h8000_0200, 0, 0);
        chk("eret_exl", {31'd0, status_o[1]}, 32'h0);
        chk("eret_epc", epc_o, 32'hBFC0_0FFC);

        // Writable-field masks
        mtc0(12, 32'hFFFF_FFFF);
        chk("status_mask", status_o, 32'h0040_FF03);
        mtc0(13, 32'hFFFF_FFFF);
        chk("cause_swip", {30'd0, cause_o[9:8]}, 32'h3);
        mtc0(12, 32'h0);

        // MTC0 EPC flushed by same-cycle overflow
        step(0, 1, 14, 14, 32'h1234, 0, 32'hc, 32'h8000_0040, 0, 0);
        chk("flush_epc", epc_o, 32'h8000_0040);
        chk("flush_exccode", {27'd0, cause_o[6:2]}, 32'd12);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            wa = WA_TAB[$urandom_range(0, 7)];
            ra = 5'($urandom_range(0, 31));
            et = ($urandom_range(0, 3) == 0) ? ET_TAB[$urandom_range(0, 10)] : 32'h0;
            d  = ($urandom_range(0, 1) == 1) ? $urandom : m_count + 32'($urandom_range(0, 6));
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), wa, ra, d,
                 6'($urandom), et, $urandom, 1'($urandom), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
